// File: rtl/double_dabble_seq_if.sv
// double_dabble_seq_if
// Purpose : groups the start/busy/done handshake and result bus of the
//           sequential binary-to-BCD converter.
// Signals : Start_i, Binary_i         - conversion request and operand (master drives)
//           Busy_o, Done_o            - progress / one-cycle completion pulse
//           BCD_o, Overflow_o         - registered result, held until next Done_o
//           DigitEn_o                 - per-digit display enable
// Modports: master (requester / display side), slave (converter).
interface double_dabble_seq_if #(
    parameter int unsigned INPUT_BITS    = 16,
    parameter int unsigned OUTPUT_DIGITS = 5
);
    logic                         Start_i;
    logic [INPUT_BITS-1:0]        Binary_i;
    logic                         Busy_o;
    logic                         Done_o;
    logic [OUTPUT_DIGITS*4-1:0]   BCD_o;
    logic                         Overflow_o;
    logic [OUTPUT_DIGITS-1:0]     DigitEn_o;

    modport master (
        output Start_i, Binary_i,
        input  Busy_o, Done_o, BCD_o, Overflow_o, DigitEn_o
    );

    modport slave (
        input  Start_i, Binary_i,
        output Busy_o, Done_o, BCD_o, Overflow_o, DigitEn_o
    );
endinterface

// File: rtl/double_dabble_seq.sv
// double_dabble_seq
// Purpose : sequential binary-to-BCD converter, one add-3/shift step per clock.
//           A conversion takes INPUT_BITS cycles of Busy_o, followed by a
//           one-cycle Done_o pulse in IDLE. Inputs that need more than
//           OUTPUT_DIGITS digits saturate BCD_o to all nines and set Overflow_o.
// Ports   : Clock - rising-edge clock
//           Reset - synchronous, active-high reset
//           bus   - double_dabble_seq_if.slave (Start_i, Binary_i, Busy_o,
//                   Done_o, BCD_o, Overflow_o, DigitEn_o)
// Macro   : DOUBLE_DABBLE_SEQ_BLANK_EN - when defined, DigitEn_o blanks leading
//           zero digits and is registered with BCD_o; otherwise it is all ones.
module double_dabble_seq #(
    parameter int unsigned INPUT_BITS    = 16,
    parameter int unsigned OUTPUT_DIGITS = 5,
    localparam int unsigned OUTPUT_BITS  = OUTPUT_DIGITS * 4
) (
    input logic                 Clock,
    input logic                 Reset,
    double_dabble_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(INPUT_BITS + 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t                   r_state,  w_state_d;
    logic [INPUT_BITS-1:0]    r_shift,  w_shift_d;
    logic [OUTPUT_BITS-1:0]   r_acc,    w_acc_d;
    logic [CNT_W-1:0]         r_cnt,    w_cnt_d;
    logic                     r_sticky, w_sticky_d;
    logic [OUTPUT_BITS-1:0]   r_bcd,    w_bcd_d;
    logic                     r_ovf,    w_ovf_d;
    logic                     r_done,   w_done_d;

    logic [OUTPUT_BITS-1:0]   w_acc_adj;
    logic [OUTPUT_BITS-1:0]   w_acc_sh;
    logic [INPUT_BITS-1:0]    w_shift_sh;
    logic                     w_sticky_sh;

    // Shared add-3 stage: each digit corrected independently, no inter-digit carry.
    always_comb begin
        w_acc_adj = r_acc;
        for (int k = 0; k < OUTPUT_DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_acc_sh    = {w_acc_adj[OUTPUT_BITS-2:0], r_shift[INPUT_BITS-1]};
    assign w_shift_sh  = r_shift << 1;
    // Any bit shifted out of the top digit means the value no longer fits.
    assign w_sticky_sh = r_sticky | w_acc_adj[OUTPUT_BITS-1];

`ifdef DOUBLE_DABBLE_SEQ_BLANK_EN
    logic [OUTPUT_DIGITS-1:0] r_digit_en, w_digit_en_d, w_en_calc;
    logic                     w_any;

    // Enable a digit when it or any more-significant digit is nonzero.
    always_comb begin
        w_any     = 1'b0;
        w_en_calc = '0;
        for (int k = OUTPUT_DIGITS - 1; k >= 0; k--) begin
            w_any        = w_any | (w_acc_sh[4*k +: 4] != 4'd0);
            w_en_calc[k] = w_any;
        end
        w_en_calc[0] = 1'b1;
        if (w_sticky_sh) begin
            w_en_calc = '1;
        end
    end

    always_comb begin
        w_digit_en_d = r_digit_en;
        if ((r_state == StShift) && (r_cnt == CNT_W'(1))) begin
            w_digit_en_d = w_en_calc;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_digit_en <= '1;
        end else begin
            r_digit_en <= w_digit_en_d;
        end
    end

    assign bus.DigitEn_o = r_digit_en;
`else
    assign bus.DigitEn_o = '1;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_shift_d  = r_shift;
        w_acc_d    = r_acc;
        w_cnt_d    = r_cnt;
        w_sticky_d = r_sticky;
        w_bcd_d    = r_bcd;
        w_ovf_d    = r_ovf;
        w_done_d   = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.Start_i) begin
                    w_shift_d  = bus.Binary_i;
                    w_acc_d    = '0;
                    w_sticky_d = 1'b0;
                    w_cnt_d    = CNT_W'(INPUT_BITS);
                    w_state_d  = StShift;
                end
            end
            StShift: begin
                w_shift_d  = w_shift_sh;
                w_acc_d    = w_acc_sh;
                w_sticky_d = w_sticky_sh;
                w_cnt_d    = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_ovf_d   = w_sticky_sh;
                    w_bcd_d   = w_sticky_sh ? {OUTPUT_DIGITS{4'h9}} : w_acc_sh;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_shift  <= w_shift_d;
            r_acc    <= w_acc_d;
            r_cnt    <= w_cnt_d;
            r_sticky <= w_sticky_d;
            r_bcd    <= w_bcd_d;
            r_ovf    <= w_ovf_d;
            r_done   <= w_done_d;
        end
    end

    assign bus.Busy_o     = (r_state == StShift);
    assign bus.Done_o     = r_done;
    assign bus.BCD_o      = r_bcd;
    assign bus.Overflow_o = r_ovf;
endmodule
